cache_fill_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 23 ++
 rtl/fill_word_counter.sv | 37 +++
 rtl/cache_fill_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field layout for the cache miss/fill controller.
// Byte address split: tag [15:11], index [10:4], word [3:1], byte [0].
package cache_pkg;

    localparam int ADDR_W        = 16;
    localparam int IDX_W         = 7;
    localparam int WORD_W        = 3;
    localparam int TAG_W         = 5;
    localparam int TAG_LSB       = 11;
    localparam int IDX_LSB       = 4;
    localparam int WORD_LSB      = 1;
    localparam int WORDS_PER_BLK = 8;
    localparam int MEM_LAT       = 4;
    localparam int MISS_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fill_state_t;

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for a block fill: sync clear, enable, last flag at final word.
// Used once for issued reads and once for returned words.
module fill_word_counter
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [WORD_W-1:0] cnt,
    output logic              last
);

    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == WORD_W'(WORDS_PER_BLK - 1));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Direct-mapped cache miss controller: streams an 8-word block from memory.
// Optional miss counter port enabled by defining CACHE_MISS_CNT_EN.
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              hit,
    output logic              stall,
    output logic [IDX_W-1:0]  blk_idx,
    output logic [WORD_W-1:0] word_idx,
    output logic              data_we,
    output logic              tag_we,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid
`ifdef CACHE_MISS_CNT_EN
    ,
    output logic [MISS_CNT_W-1:0] miss_count
`endif
);

    fill_state_t state_q;
    fill_state_t state_d;

    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  tag_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [WORD_W-1:0] issue_cnt;
    logic [WORD_W-1:0] recv_cnt;
    logic              issue_last;
    logic              recv_last;
    logic              miss;
    logic              cnt_clr;
    logic              issue_en;
    logic              recv_en;
    logic              unused_byte;

    assign unused_byte = req_addr[0];
    assign miss        = req_valid & ~hit;
    assign cnt_clr     = (state_q == IDLE) & miss;
    assign issue_en    = (state_q == ISSUE);
    // Returns are only accepted while a fill is outstanding.
    assign recv_en     = mem_valid &
                         ((state_q == ISSUE) | (state_q == DRAIN));

    fill_word_counter u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (issue_en),
        .cnt  (issue_cnt),
        .last (issue_last)
    );

    fill_word_counter u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (recv_en),
        .cnt  (recv_cnt),
        .last (recv_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d = ISSUE;
                    tag_d   = req_addr[TAG_LSB +: TAG_W];
                    idx_d   = req_addr[IDX_LSB +: IDX_W];
                end
            end
            ISSUE: begin
                if (issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_valid && recv_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall    = 1'b1;
        blk_idx  = idx_q;
        word_idx = recv_cnt;
        data_we  = 1'b0;
        tag_we   = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        unique case (state_q)
            IDLE: begin
                stall    = miss;
                blk_idx  = req_addr[IDX_LSB +: IDX_W];
                word_idx = req_addr[WORD_LSB +: WORD_W];
            end
            ISSUE: begin
                data_we  = mem_valid;
                mem_en   = 1'b1;
                mem_addr = {tag_q, idx_q, issue_cnt, 1'b0};
            end
            DRAIN: begin
                data_we = mem_valid;
            end
            DONE: begin
                tag_we = 1'b1;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

`ifdef CACHE_MISS_CNT_EN
    logic [MISS_CNT_W-1:0] miss_count_q;
    logic [MISS_CNT_W-1:0] miss_count_d;

    // Saturates so a long-running count never rolls back to a small value.
    always_comb begin
        miss_count_d = miss_count_q;
        if (state_q == DONE && miss_count_q != '1) begin
            miss_count_d = miss_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_q <= '0;
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a fixed-latency memory model.
// Miss counter checks are built only when CACHE_MISS_CNT_EN is defined.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        hit;
    logic        stall;
    logic [6:0]  blk_idx;
    logic [2:0]  word_idx;
    logic        data_we;
    logic        tag_we;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic        stray;
    logic [3:0]  mem_pipe;
`ifdef CACHE_MISS_CNT_EN
    logic [15:0] miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cache_fill_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .hit       (hit),
        .stall     (stall),
        .blk_idx   (blk_idx),
        .word_idx  (word_idx),
        .data_we   (data_we),
        .tag_we    (tag_we),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid)
`ifdef CACHE_MISS_CNT_EN
        ,
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers each read exactly 4 cycles after issue, in order.
    always @(posedge clk) begin
        if (rst) mem_pipe <= '0;
        else     mem_pipe <= {mem_pipe[2:0], mem_en};
    end
    assign mem_valid = mem_pipe[3] | stray;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full miss of 0x1234, checked cycle by cycle from detection to replay.
    task automatic run_miss(input bit disturb);
        for (int c = 0; c <= 14; c++) begin
            if (c == 0) begin
                req_valid = 1'b1; req_addr = 16'h1234; hit = 1'b0;
            end else if (c == 14) begin
                req_valid = 1'b1; req_addr = 16'h1234; hit = 1'b1;
            end else if (disturb) begin
                req_valid = 1'b1; req_addr = 16'hFFF0; hit = 1'b0;
            end else begin
                req_valid = 1'b0; req_addr = 16'h1234; hit = 1'b0;
            end
            #1;
            chk($sformatf("stall c%0d", c), 16'(stall), 16'(c <= 13));
            chk($sformatf("blk_idx c%0d", c), 16'(blk_idx), 16'h23);
            chk($sformatf("mem_en c%0d", c), 16'(mem_en),
                16'(c >= 1 && c <= 8));
            if (c >= 1 && c <= 8)
                chk($sformatf("mem_addr c%0d", c), mem_addr,
                    16'(16'h1230 + 2 * (c - 1)));
            chk($sformatf("data_we c%0d", c), 16'(data_we),
                16'(c >= 5 && c <= 12));
            if (c >= 5 && c <= 12)
                chk($sformatf("word_idx c%0d", c), 16'(word_idx), 16'(c - 5));
            if (c == 0 || c == 14)
                chk($sformatf("word_idx c%0d", c), 16'(word_idx), 16'd2);
            chk($sformatf("tag_we c%0d", c), 16'(tag_we), 16'(c == 13));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0456;
        hit = 1'b0; stray = 1'b0;
        tick();
        tick();
        #1;
        chk("rst stall", 16'(stall), 16'd0);
        chk("rst blk_idx", 16'(blk_idx), 16'h45);
        chk("rst word_idx", 16'(word_idx), 16'd3);
        chk("rst data_we", 16'(data_we), 16'd0);
        chk("rst tag_we", 16'(tag_we), 16'd0);
        chk("rst mem_en", 16'(mem_en), 16'd0);
        chk("rst mem_addr", mem_addr, 16'h0000);
`ifdef CACHE_MISS_CNT_EN
        chk("rst miss_count", miss_count, 16'd0);
`endif
        rst = 1'b0;
        tick();

        req_valid = 1'b1; req_addr = 16'h1234; hit = 1'b1;
        #1;
        chk("hit stall", 16'(stall), 16'd0);
        chk("hit blk_idx", 16'(blk_idx), 16'h23);
        chk("hit word_idx", 16'(word_idx), 16'd2);
        chk("hit mem_en", 16'(mem_en), 16'd0);
        tick();
        chk("hit next stall", 16'(stall), 16'd0);
        chk("hit next mem_en", 16'(mem_en), 16'd0);
        req_valid = 1'b0;
        tick();

        run_miss(1'b0);
        run_miss(1'b1);
        chk("after disturb mem_en", 16'(mem_en), 16'd0);
        chk("after disturb stall", 16'(stall), 16'd0);

        stray = 1'b1; req_addr = 16'h1234; hit = 1'b0;
        #1;
        chk("stray data_we", 16'(data_we), 16'd0);
        chk("stray stall", 16'(stall), 16'd0);
        tick();
        stray = 1'b0;
        #1;
        chk("stray next mem_en", 16'(mem_en), 16'd0);
        chk("stray next stall", 16'(stall), 16'd0);
        chk("stray next word_idx", 16'(word_idx), 16'd2);
        tick();

        req_valid = 1'b1; req_addr = 16'h1234; hit = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst stall", 16'(stall), 16'd0);
        chk("midrst mem_en", 16'(mem_en), 16'd0);
        chk("midrst tag_we", 16'(tag_we), 16'd0);
        chk("midrst data_we", 16'(data_we), 16'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("midrst idle tag_we %0d", c), 16'(tag_we), 16'd0);
            chk($sformatf("midrst idle mem_en %0d", c), 16'(mem_en), 16'd0);
        end
`ifdef CACHE_MISS_CNT_EN
        chk("midrst miss_count", miss_count, 16'd0);
`endif

        run_miss(1'b0);
        run_miss(1'b0);
        run_miss(1'b0);
`ifdef CACHE_MISS_CNT_EN
        chk("miss_count three", miss_count, 16'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
